ram_dm: RTL and testbench

RAM_DM -- requirements
Module: ram_dm

---
 rtl/ram_dm.sv | 40 ++++
 tb/tb_ram_dm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ram_dm.sv
// ram_dm: single-port data memory, write-first, one-cycle registered read.
// Define RAM_DM_INIT_EN to power up with mem[1]=701 and every other word 0.
module ram_dm #(
   parameter int DATA_W = 11,
   parameter int ADDR_W = 11
) (
   input  logic              CLK_i,
   input  logic              RST_n_i,
   input  logic              WR_i,
   input  logic [ADDR_W-1:0] ADDR_dm_i,
   input  logic [DATA_W-1:0] IN_DATA_i,
   output logic [DATA_W-1:0] OUT_DATA_o
);

   localparam int DEPTH = 2**ADDR_W;

`ifdef RAM_DM_INIT_EN
   logic [DATA_W-1:0] mem [DEPTH] = '{1: DATA_W'(701), default: '0};
`else
   logic [DATA_W-1:0] mem [DEPTH];
`endif

   // Array has no reset; reset only blocks the write.
   always_ff @(posedge CLK_i) begin
      if (RST_n_i && WR_i) begin
         mem[ADDR_dm_i] <= IN_DATA_i;
      end
   end

   always_ff @(posedge CLK_i or negedge RST_n_i) begin
      if (!RST_n_i) begin
         OUT_DATA_o <= '0;
      end else if (WR_i) begin
         OUT_DATA_o <= IN_DATA_i;
      end else begin
         OUT_DATA_o <= mem[ADDR_dm_i];
      end
   end

endmodule

// File: tb/tb_ram_dm.sv
// tb_ram_dm: directed and random checks of ram_dm against an
// associative-array memory model.
module tb_ram_dm;

   logic        clk;
   logic        rst_n;
   logic        wr;
   logic [10:0] addr;
   logic [10:0] din;
   logic [10:0] dout;

   int checks   = 0;
   int failures = 0;

   logic [10:0] model [int];
   int          written [$];

   ram_dm #(.DATA_W(11), .ADDR_W(11)) dut (
      .CLK_i      (clk),
      .RST_n_i    (rst_n),
      .WR_i       (wr),
      .ADDR_dm_i  (addr),
      .IN_DATA_i  (din),
      .OUT_DATA_o (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [10:0] got,
                      input logic [10:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic remember(input int a);
      foreach (written[i]) if (written[i] == a) return;
      written.push_back(a);
   endtask

   // One clocked operation, then scramble inputs mid-cycle and
   // confirm the output holds.
   task automatic op(input string tag, input logic w, input int a,
                     input logic [10:0] d);
      logic [10:0] exp;
      @(negedge clk);
      wr   = w;
      addr = 11'(a);
      din  = d;
      @(posedge clk);
      #1;
      if (w) begin
         model[a] = d;
         remember(a);
         exp = d;
      end else begin
         exp = model[a];
      end
      chk(tag, dout, exp);
      wr   = 1'($urandom);
      addr = 11'($urandom);
      din  = 11'($urandom);
      #1;
      chk({tag, "_hold"}, dout, exp);
   endtask

   initial begin
      rst_n = 1'b1;
      wr    = 1'b0;
      addr  = '0;
      din   = '0;
`ifdef RAM_DM_INIT_EN
      model[1] = 11'd701;
      for (int i = 0; i < 16; i++) if (i != 1) model[i] = 11'd0;
`endif
      #1;
      rst_n = 1'b0;
      #1;
      chk("reset_async", dout, 11'd0);
      addr = 11'd1;
      @(posedge clk);
      #1;
      chk("reset_hold_edge", dout, 11'd0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef RAM_DM_INIT_EN
      op("init_read1", 1'b0, 1, 11'd0);
      op("init_read3", 1'b0, 3, 11'd0);
      addr = 11'd1;
      #2;
      chk("addr_change_no_edge", dout, 11'd0);
`endif

      op("wr1_zero", 1'b1, 1, 11'd0);
      op("rd1_zero", 1'b0, 1, 11'd0);
      op("wr1_two", 1'b1, 1, 11'd2);
      op("rd1_two", 1'b0, 1, 11'd2);

      // Reset mid-cycle while a write is presented.
      @(negedge clk);
      wr   = 1'b1;
      addr = 11'd1;
      din  = 11'd5;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midcycle_reset", dout, 11'd0);
      @(posedge clk);
      #1;
      chk("reset_write_blocked_out", dout, 11'd0);
      @(negedge clk);
      wr    = 1'b0;
      rst_n = 1'b1;
      op("after_reset_rd1", 1'b0, 1, 11'd0);

      op("wr_top", 1'b1, 2047, 11'h7FF);
      op("wr_zero", 1'b1, 0, 11'h001);
      op("rd_top", 1'b0, 2047, 11'd0);
      op("rd_zero", 1'b0, 0, 11'd0);

      op("wr5_a", 1'b1, 5, 11'h0AA);
      op("wr5_b", 1'b1, 5, 11'h155);
      op("rd5_last", 1'b0, 5, 11'd0);

      for (int n = 0; n < 300; n++) begin
         int a;
         if (($urandom_range(0, 1) == 0) || (written.size() == 0)) begin
            case ($urandom_range(0, 3))
               0: a = 0;
               1: a = 2047;
               default: a = int'($urandom_range(0, 31));
            endcase
            op("rnd_wr", 1'b1, a, 11'($urandom));
         end else begin
            a = written[$urandom_range(0, written.size() - 1)];
            op("rnd_rd", 1'b0, a, 11'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
